// File: rtl/status_sticky_ctrl_if.sv
// Bus-side read path of the status controller.
// Handshake: rd_req is a level the CPU raises and holds until it sees rd_ack.
// rd_ack high means rd_data holds a stable snapshot. The CPU then drops rd_req,
// and rd_ack falls at the next clock edge. ovr and irq are free-running status
// outputs and are not part of the handshake.
interface status_sticky_ctrl_if;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [7:0] ovr;
    logic       irq;

    // CPU / bus side
    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_data,
        input  ovr,
        input  irq
    );

    // Status controller side
    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_data,
        output ovr,
        output irq
    );
endinterface

// File: rtl/status_sticky_ctrl.sv
// Front-end controller for an 8-bit CPU-readable status register.
// Each bit is either transparent (it follows the input) or sticky (it holds
// until a read clears it). A read takes a snapshot, and only the sticky bits in
// that snapshot are cleared. Events that arrive after the snapshot survive.
// Optional feature macro: STATUS_STICKY_EDGE_EN. When it is defined, sticky bits
// latch only on a rising edge of their input. When it is undefined, they latch
// on the input level.
// The debug outputs show the FSM state (0=IDLE, 1=CAPTURE, 2=ACK) and the
// internal status register.
module status_sticky_ctrl #(
    parameter int         NumInputs = 8,
    parameter logic [7:0] ModeMask  = 8'h00,
    parameter logic [7:0] IntMask   = 8'hFF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           status_in,
    status_sticky_ctrl_if.slave  bus,
    output logic [1:0]           dbg_state,
    output logic [7:0]           dbg_stat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    // Bits at or above NumInputs do not exist and always read as 0.
    localparam logic [7:0] ActMask = 8'((9'd1 << NumInputs) - 9'd1);

    state_t     state;
    logic [7:0] s_q;
    logic [7:0] set;
    logic [7:0] clr;
    logic [7:0] stat;
    logic [7:0] stat_next;
    logic [7:0] ovr_q;
    logic [7:0] ovr_next;
    logic       irq_q;
    logic       rd_ack_q;
    logic [7:0] rd_data_q;

`ifdef STATUS_STICKY_EDGE_EN
    logic [7:0] s_qd;

    // Delayed copy of the input stage, used to detect rising edges
    always_ff @(posedge clock) begin
        if (!reset_n) s_qd <= 8'h00;
        else          s_qd <= s_q;
    end

    assign set = s_q & ~s_qd;
`else
    assign set = s_q;
`endif

    // Input stage: register the status nets and drop the bits that do not exist
    always_ff @(posedge clock) begin
        if (!reset_n) s_q <= 8'h00;
        else          s_q <= status_in & ActMask;
    end

    // Next-state logic for the status and overrun registers. Clear is pulsed only
    // in CAPTURE, and only for sticky bits. On a sticky bit, a set wins over a
    // clear in the same cycle.
    always_comb begin
        clr       = 8'h00;
        if (state == CAPTURE) clr = stat & ModeMask;
        stat_next = (ModeMask & ((stat & ~clr) | set)) | (~ModeMask & s_q);
        ovr_next  = ModeMask & ((ovr_q & ~clr) | (set & stat & ~clr));
    end

    // Status, overrun and interrupt registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat  <= 8'h00;
            ovr_q <= 8'h00;
            irq_q <= 1'b0;
        end else begin
            stat  <= stat_next;
            ovr_q <= ovr_next;
            irq_q <= |(stat & ModeMask & IntMask);
        end
    end

    // Read handshake FSM. It snapshots stat in CAPTURE, holds rd_ack in ACK, and
    // returns to IDLE once rd_req drops.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_ack_q  <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack_q <= 1'b0;
                    if (bus.rd_req) state <= CAPTURE;
                end
                CAPTURE: begin
                    rd_data_q <= stat;
                    rd_ack_q  <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    if (!bus.rd_req) begin
                        rd_ack_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    rd_ack_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;
    assign bus.ovr     = ovr_q;
    assign bus.irq     = irq_q;
    assign dbg_state   = state;
    assign dbg_stat    = stat;

endmodule
